seg7_scanner: RTL and testbench

SEG7_SCANNER -- requirements
Module: seg7_scanner

---
 rtl/seg7_scanner.sv | 126 ++++++++++++
 tb/tb_seg7_scanner.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scanner.sv
// seg7_scanner: four-digit multiplexed hex display driver.
// The tick_in scan clock is synchronised and edge-detected. Each detected
// edge steps the digit index. Digit and decimal-point data are captured once
// per frame, on the 3->0 wrap, so that one frame never shows a mix of old and
// new values. The anode, segment and decimal-point outputs are registered and
// follow the index one clock later.
//
// Handshake note: this block has no valid/ready interface. The scan_en pulse
// is the only internal event. It is one clock wide for each rising edge of the
// synchronised tick.
module seg7_scanner (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_in,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        enable,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  digit_sel
);

  // Synchroniser chain (s1, s2) plus the history flop s3 used for edge detection.
  logic s1_q, s2_q, s3_q;
  logic scan_en;

  // Scan index. The shadow register holds {dp[3:0], digits[15:0]} for the current frame.
  logic [1:0]  sel_q, sel_d;
  logic [19:0] shadow_q, shadow_d;

  // Registered display outputs.
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;

  // Decode of the selected nibble and leading-zero flags.
  logic [3:0] cur_nib;
  logic [3:0] lz_zero;

  // Converts a hex nibble to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex2seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign scan_en = s2_q & ~s3_q;

  // Next-state logic for the scan index and the frame shadow, and the next
  // values of the registered outputs.
  always_comb begin
    sel_d    = sel_q;
    shadow_d = shadow_q;
    an_d     = 4'b1111;
    seg_d    = 7'b1111111;
    dp_d     = 1'b1;
    cur_nib  = shadow_q[{sel_q, 2'b00} +: 4];

    // Digit i is a leading zero if nibbles i..3 are all zero. Digit 0 never is.
    lz_zero[3] = (shadow_q[15:12] == 4'h0);
    lz_zero[2] = (shadow_q[15:8]  == 8'h00);
    lz_zero[1] = (shadow_q[15:4]  == 12'h000);
    lz_zero[0] = 1'b0;

    if (scan_en) begin
      sel_d = sel_q + 2'd1;
      if (sel_q == 2'd3) begin
        shadow_d = {dp_in, digits};
      end
    end

    if (enable) begin
      an_d  = 4'b1111 ^ (4'b0001 << sel_q);
      seg_d = (blank_lz && lz_zero[sel_q]) ? 7'b1111111 : hex2seg(cur_nib);
      dp_d  = ~shadow_q[16 + {3'b000, sel_q}];
    end
  end

  // State registers. Reset takes priority over a scan_en pulse in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      sel_q    <= 2'd0;
      shadow_q <= 20'd0;
      an_q     <= 4'b1111;
      seg_q    <= 7'b1111111;
      dp_q     <= 1'b1;
    end else begin
      s1_q     <= tick_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_sel = sel_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// Bench for seg7_scanner. It steps the scanner with table-driven frames and
// checks each digit against a scoreboard. It also runs hand-written sequences
// for latency, frame coherence, reset and enable behaviour.
module tb_seg7_scanner;

  localparam int W = 14; // {sel[1:0], an[3:0], seg[6:0], dp}

  logic        clk = 1'b0;
  logic        reset;
  logic        tick_in;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        enable;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_sel;

  // Clock and reset block.
  always #5 clk = ~clk;

  seg7_scanner dut (
    .clk       (clk),
    .reset     (reset),
    .tick_in   (tick_in),
    .digits    (digits),
    .dp_in     (dp_in),
    .enable    (enable),
    .blank_lz  (blank_lz),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .digit_sel (digit_sel)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Reference model: scan index plus the latched frame.
  int         m_sel;
  logic [3:0] m_nib [4];
  logic [3:0] m_dpin;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic        blz;
    logic [27:0] seg_exp; // {d3, d2, d1, d0}
    logic [3:0]  dp_exp;  // active-low, {d3..d0}
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model_out();
    logic [6:0] s;
    logic [3:0] a;
    logic       d;
    bit         blank;
    blank = 1'b0;
    if (blank_lz && m_sel != 0) begin
      blank = 1'b1;
      for (int k = m_sel; k < 4; k++) if (m_nib[k] != 4'h0) blank = 1'b0;
    end
    if (enable) begin
      a = an_tab[m_sel];
      s = blank ? 7'b1111111 : seg_tab[m_nib[m_sel]];
      d = ~m_dpin[m_sel];
    end else begin
      a = 4'b1111;
      s = 7'b1111111;
      d = 1'b1;
    end
    return {2'(m_sel), a, s, d};
  endfunction

  task automatic model_advance();
    m_sel = (m_sel + 1) % 4;
    if (m_sel == 0) begin
      for (int k = 0; k < 4; k++) m_nib[k] = digits[k*4 +: 4];
      m_dpin = dp_in;
    end
  endtask

  task automatic model_clear();
    m_sel  = 0;
    m_dpin = 4'h0;
    for (int k = 0; k < 4; k++) m_nib[k] = 4'h0;
  endtask

  task automatic check_word(input string tag, input logic [W-1:0] e);
    check({tag, ".sel"}, 16'(digit_sel), 16'(e[13:12]));
    check({tag, ".an"},  16'(an),        16'(e[11:8]));
    check({tag, ".seg"}, 16'(seg),       16'(e[7:1]));
    check({tag, ".dp"},  16'(dp),        16'(e[0]));
  endtask

  task automatic pop_and_check(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 16'd0, 16'd1);
    end else begin
      e = exp_q.pop_front();
      check_word(tag, e);
    end
  endtask

  // Driver task: one tick_in period (8 clk high, 8 clk low). It is entered and
  // left on a negedge.
  task automatic tick();
    model_advance();
    exp_q.push_back(model_out());
    tick_in = 1'b1;
    repeat (8) @(negedge clk);
    tick_in = 1'b0;
    repeat (8) @(negedge clk);
    pop_and_check($sformatf("tick.sel%0d", m_sel));
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int old;

    vecs[0] = '{16'h12AF, 4'b0100, 1'b0,
                {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1011};
    vecs[1] = '{16'h0050, 4'b0000, 1'b1,
                {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}, 4'b1111};
    vecs[2] = '{16'h0050, 4'b0000, 1'b0,
                {7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000}, 4'b1111};
    vecs[3] = '{16'h3456, 4'b1111, 1'b0,
                {7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}, 4'b0000};
    vecs[4] = '{16'h789B, 4'b0001, 1'b0,
                {7'b1111000, 7'b0000000, 7'b0010000, 7'b0000011}, 4'b1110};
    vecs[5] = '{16'hCDE0, 4'b0000, 1'b1,
                {7'b1000110, 7'b0100001, 7'b0000110, 7'b1000000}, 4'b1111};
    vecs[6] = '{16'h0000, 4'b1010, 1'b1,
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b0101};
    vecs[7] = '{16'h0D00, 4'b0000, 1'b1,
                {7'b1111111, 7'b0100001, 7'b1000000, 7'b1000000}, 4'b1111};

    // Reset with no ticks.
    reset    = 1'b1;
    tick_in  = 1'b0;
    digits   = 16'h0000;
    dp_in    = 4'h0;
    enable   = 1'b1;
    blank_lz = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst.an",  16'(an),        16'hF);
    check("rst.seg", 16'(seg),       16'h7F);
    check("rst.dp",  16'(dp),        16'd1);
    check("rst.sel", 16'(digit_sel), 16'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle.an",  16'(an),        16'(4'b1110));
    check("idle.seg", 16'(seg),       16'(7'b1000000));
    check("idle.dp",  16'(dp),        16'd1);
    check("idle.sel", 16'(digit_sel), 16'd0);

    // Table-driven frames: load the inputs, scan to the wrap, then check every digit.
    for (int v = 0; v < 8; v++) begin
      digits   = vecs[v].digits;
      dp_in    = vecs[v].dp_in;
      blank_lz = vecs[v].blz;
      do tick(); while (m_sel != 0);
      for (int i = 0; i < 4; i++) begin
        if (i != 0) tick();
        check($sformatf("vec%0d.d%0d.seg", v, i), 16'(seg), 16'(vecs[v].seg_exp[i*7 +: 7]));
        check($sformatf("vec%0d.d%0d.dp", v, i),  16'(dp),  16'(vecs[v].dp_exp[i]));
      end
    end

    // Latency: digit_sel changes at E2 and an changes at E3. A held-high
    // tick_in gives exactly one advance.
    old = m_sel;
    model_advance();
    exp_q.push_back(model_out());
    tick_in = 1'b1;
    @(negedge clk);
    check("lat.E0.sel", 16'(digit_sel), 16'(old));
    @(negedge clk);
    check("lat.E1.sel", 16'(digit_sel), 16'(old));
    @(negedge clk);
    check("lat.E2.sel", 16'(digit_sel), 16'(m_sel));
    check("lat.E2.an",  16'(an),        16'(an_tab[old]));
    @(negedge clk);
    pop_and_check("lat.E3");
    repeat (100) @(negedge clk);
    check("lat.hold.sel", 16'(digit_sel), 16'(m_sel));
    tick_in = 1'b0;
    repeat (8) @(negedge clk);

    // Frame coherence: a digits change mid-frame shows only after the wrap.
    digits   = 16'h1111;
    dp_in    = 4'h0;
    blank_lz = 1'b0;
    do tick(); while (m_sel != 0);
    tick();
    check("coh.d1.seg", 16'(seg), 16'(7'b1111001));
    digits = 16'h2222;
    tick();
    check("coh.d2.seg", 16'(seg), 16'(7'b1111001));
    tick();
    check("coh.d3.seg", 16'(seg), 16'(7'b1111001));
    tick();
    check("coh.wrap.d0.seg", 16'(seg), 16'(7'b0100100));
    tick();
    check("coh.wrap.d1.seg", 16'(seg), 16'(7'b0100100));
    tick(); // digit_sel = 2

    // Reset coincident with scan_en at digit_sel=2, while tick_in stays high
    // across the reset release.
    tick_in = 1'b1;
    @(posedge clk);   // E0
    @(posedge clk);   // E1: scan_en is now high
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);   // E2 taken under reset
    check("rst_mid.sel", 16'(digit_sel), 16'd0);
    check("rst_mid.an",  16'(an),        16'hF);
    check("rst_mid.seg", 16'(seg),       16'h7F);
    reset = 1'b0;
    model_clear();
    @(negedge clk);   // R1
    check("rel.R1.sel", 16'(digit_sel), 16'd0);
    check("rel.R1.an",  16'(an),        16'(4'b1110));
    check("rel.R1.seg", 16'(seg),       16'(7'b1000000));
    @(negedge clk);   // R2
    check("rel.R2.sel", 16'(digit_sel), 16'd0);
    @(negedge clk);   // R3
    check("rel.R3.sel", 16'(digit_sel), 16'd1);
    @(negedge clk);   // R4
    check("rel.R4.an",  16'(an),  16'(4'b1101));
    check("rel.R4.seg", 16'(seg), 16'(7'b1000000));
    check("rel.R4.dp",  16'(dp),  16'd1);
    tick_in = 1'b0;
    m_sel   = 1;
    repeat (8) @(negedge clk);

    // Enable low: dark outputs from the next edge, while scanning continues.
    enable = 1'b0;
    @(negedge clk);
    check("dark.an",  16'(an),  16'hF);
    check("dark.seg", 16'(seg), 16'h7F);
    check("dark.dp",  16'(dp),  16'd1);
    tick();
    enable = 1'b1;
    tick();
    tick();

    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
